// File: rtl/blk_a9bc11_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter.
// Holds the FSM state encoding, the read-owner encoding, the RAM read
// latency and the read-tag record carried down the return pipe.
package blk_a9bc11_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Owner of an in-flight read
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // Clocks from address issue to valid ram_do
    localparam int unsigned RDLAT = 2;

    typedef struct packed {
        logic vld;
        logic own;
    } rdtag_t;

endpackage

// File: rtl/blk_a9bc11_rdtag.sv
// spram_rdtag: RDLAT-deep shift register of {valid, owner} tags that
// tracks granted reads until their data appears on ram_do.
//   clk    in  clock
//   clr    in  synchronous clear (drops all in-flight reads)
//   push   in  tag of the read issued this cycle (vld=0 for no read)
//   a_rvld out read data on ram_do belongs to requester A
//   b_rvld out read data on ram_do belongs to requester B
module spram_rdtag
    import blk_a9bc11_pkg::*;
(
    input  logic   clk,
    input  logic   clr,
    input  rdtag_t push,
    output logic   a_rvld,
    output logic   b_rvld
);

    logic [RDLAT-1:0] vld_q, vld_d;
    logic [RDLAT-1:0] own_q, own_d;

    always_comb begin
        vld_d = {vld_q[RDLAT-2:0], push.vld};
        own_d = {own_q[RDLAT-2:0], push.own};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    // Gated by clr so no valid is reported during the reset cycle itself.
    always_comb begin
        a_rvld = !clr && vld_q[RDLAT-1] && (own_q[RDLAT-1] == OWN_A);
        b_rvld = !clr && vld_q[RDLAT-1] && (own_q[RDLAT-1] == OWN_B);
    end

endmodule

// File: rtl/blk_a9bc11.sv
// blk_a9bc11: shares one single-port RAM (2-clock registered read) between
// requesters A and B. After reset it sweeps INITVAL into every location,
// then arbitrates round-robin and steers read data back to its issuer.
//   clk, rst                  clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdat  requester A access (held until a_gnt)
//   a_gnt, a_rvld             A accepted this cycle, A read data valid
//   b_*                       same for requester B
//   rdat                      shared read data, qualified by a_rvld/b_rvld
//   ram_a/ram_we/ram_di       RAM address, write enable, write data
//   ram_do                    RAM read data, valid 2 clocks after address
//   busy                      init sweep in progress
module blk_a9bc11
    import blk_a9bc11_pkg::*;
#(
    parameter int                ADDRBIT = 11,
    parameter int                DEPTH   = 1536,
    parameter int                WIDTH   = 32,
    parameter logic [WIDTH-1:0]  INITVAL = '0
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [ADDRBIT-1:0] a_addr,
    input  logic [WIDTH-1:0]   a_wdat,
    output logic               a_gnt,
    output logic               a_rvld,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [ADDRBIT-1:0] b_addr,
    input  logic [WIDTH-1:0]   b_wdat,
    output logic               b_gnt,
    output logic               b_rvld,
    output logic [WIDTH-1:0]   rdat,
    output logic [ADDRBIT-1:0] ram_a,
    output logic               ram_we,
    output logic [WIDTH-1:0]   ram_di,
    input  logic [WIDTH-1:0]   ram_do,
    output logic               busy
);

    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    logic [0:0]         state_q, state_d;
    logic [ADDRBIT-1:0] cnt_q, cnt_d;
    logic [ADDRBIT-1:0] ram_a_q, ram_a_d;
    logic               ptr_q, ptr_d;
    logic               run;
    logic               sel_a, sel_b;
    rdtag_t             tag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ram_a_d = ram_a_q;
        ram_we  = 1'b0;
        ram_di  = '0;

        run   = (state_q == ST_RUN) && !rst;
        sel_a = run && a_req && (!b_req || (ptr_q == OWN_A));
        sel_b = run && b_req && !sel_a;

        // Pointer moves only when both competed for the slot.
        if (run && a_req && b_req) begin
            ptr_d = sel_a ? OWN_B : OWN_A;
        end

        if (state_q == ST_INIT) begin
            ram_a_d = cnt_q;
            ram_we  = !rst;
            ram_di  = INITVAL;
            cnt_d   = cnt_q + 1'b1;
            // Explicit end compare: DEPTH need not be a power of two.
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else if (sel_a) begin
            ram_a_d = a_addr;
            ram_we  = a_we;
            ram_di  = a_wdat;
        end else if (sel_b) begin
            ram_a_d = b_addr;
            ram_we  = b_we;
            ram_di  = b_wdat;
        end

        ram_a   = ram_a_d;
        a_gnt   = sel_a;
        b_gnt   = sel_b;
        busy    = rst || (state_q == ST_INIT);
        tag.vld = (sel_a && !a_we) || (sel_b && !b_we);
        tag.own = sel_b ? OWN_B : OWN_A;
        rdat    = ram_do;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ptr_q   <= OWN_A;
            ram_a_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ram_a_q <= ram_a_d;
        end
    end

    spram_rdtag u_rdtag (
        .clk    (clk),
        .clr    (rst),
        .push   (tag),
        .a_rvld (a_rvld),
        .b_rvld (b_rvld)
    );

endmodule

// File: tb/tb_blk_a9bc11.sv
// Self-checking bench for blk_a9bc11 with a behavioural RAM wrapper and a
// reference model built from request/grant/return rules.
module tb_blk_a9bc11;

    localparam int          AW    = 4;
    localparam int          DEPTH = 8;
    localparam int          W     = 32;
    localparam logic [31:0] IV    = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [W-1:0]  a_wdat = '0, b_wdat = '0;
    logic          a_gnt, a_rvld, b_gnt, b_rvld, ram_we, busy;
    logic [W-1:0]  rdat, ram_di, ram_do;
    logic [AW-1:0] ram_a;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [W-1:0] exp_mem [0:15];
    logic         rr;  // 1: B wins the next contested cycle

    typedef struct {
        int         due;
        logic       own;
        logic [W-1:0] d;
    } ret_t;

    blk_a9bc11 #(.ADDRBIT(AW), .DEPTH(DEPTH), .WIDTH(W), .INITVAL(IV)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdat(a_wdat),
        .a_gnt(a_gnt), .a_rvld(a_rvld),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdat(b_wdat),
        .b_gnt(b_gnt), .b_rvld(b_rvld),
        .rdat(rdat), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di),
        .ram_do(ram_do), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM wrapper: array read + output register = 2 clocks.
    logic [W-1:0] mem [0:15];
    logic [W-1:0] rd1;
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
        rd1    <= mem[ram_a];
        ram_do <= rd1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset;
        a_req = 1'b0;
        b_req = 1'b0;
        rst   = 1'b1;
        tick;
        rst   = 1'b0;
        rr    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b0;
        tick;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy); else pass_cnt++;
            total_cnt++;
            if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b expected 00", {a_gnt, b_gnt}); else pass_cnt++;
            total_cnt++;
            if (ram_we !== 1'b0) $display("FAIL rst_we: got %b expected 0", ram_we); else pass_cnt++;
            total_cnt++;
            if ({a_rvld, b_rvld} !== 2'b00) $display("FAIL rst_rvld: got %b expected 00", {a_rvld, b_rvld}); else pass_cnt++;
            tick;
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_init_sweep;
        start_reset;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL init_busy[%0d]: got %b expected 1", i, busy); else pass_cnt++;
            total_cnt++;
            if (ram_we !== 1'b1 || ram_a !== AW'(i) || ram_di !== IV)
                $display("FAIL init_write[%0d]: got we=%b a=%0d di=%h expected we=1 a=%0d di=%h", i, ram_we, ram_a, ram_di, i, IV);
            else pass_cnt++;
            tick;
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = (i < DEPTH) ? IV : 'x;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || a_gnt !== 1'b1)
            $display("FAIL init_first_run: got busy=%b a_gnt=%b expected busy=0 a_gnt=1", busy, a_gnt);
        else pass_cnt++;
        tick;
        a_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({a_rvld, b_rvld} !== 2'b00) $display("FAIL init_rd_early: got %b expected 00", {a_rvld, b_rvld}); else pass_cnt++;
        tick;
        @(negedge clk);
        total_cnt++;
        if (a_rvld !== 1'b1 || b_rvld !== 1'b0 || rdat !== IV)
            $display("FAIL init_rd5: got a_rvld=%b b_rvld=%b rdat=%h expected 1 0 %h", a_rvld, b_rvld, rdat, IV);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_init_request;
        start_reset;
        for (int c = 0; c < DEPTH; c++) begin
            if (c == 2) begin
                b_req = 1'b1; b_we = 1'b0; b_addr = '0;
            end
            @(negedge clk);
            if (c >= 2) begin
                total_cnt++;
                if (b_gnt !== 1'b0) $display("FAIL initreq_nognt[%0d]: got %b expected 0", c, b_gnt); else pass_cnt++;
            end
            tick;
        end
        @(negedge clk);
        total_cnt++;
        if (b_gnt !== 1'b1 || busy !== 1'b0)
            $display("FAIL initreq_gnt: got b_gnt=%b busy=%b expected 1 0", b_gnt, busy);
        else pass_cnt++;
        tick;
        b_req = 1'b0;
        tick;
        @(negedge clk);
        total_cnt++;
        if (b_rvld !== 1'b1 || a_rvld !== 1'b0 || rdat !== IV)
            $display("FAIL initreq_rvld: got b_rvld=%b a_rvld=%b rdat=%h expected 1 0 %h", b_rvld, a_rvld, rdat, IV);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_single;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdat = 32'h12345678;
        @(negedge clk);
        total_cnt++;
        if (a_gnt !== 1'b1 || ram_we !== 1'b1 || ram_a !== 4'd3 || ram_di !== 32'h12345678)
            $display("FAIL single_wr: got gnt=%b we=%b a=%0d di=%h expected 1 1 3 12345678", a_gnt, ram_we, ram_a, ram_di);
        else pass_cnt++;
        exp_mem[3] = 32'h12345678;
        tick;
        a_we = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_gnt !== 1'b1 || ram_we !== 1'b0 || ram_a !== 4'd3)
            $display("FAIL single_rd: got gnt=%b we=%b a=%0d expected 1 0 3", a_gnt, ram_we, ram_a);
        else pass_cnt++;
        tick;
        a_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_rvld !== 1'b0) $display("FAIL single_early: got %b expected 0", a_rvld); else pass_cnt++;
        tick;
        @(negedge clk);
        total_cnt++;
        if (a_rvld !== 1'b1 || rdat !== 32'h12345678)
            $display("FAIL single_raw: got a_rvld=%b rdat=%h expected 1 12345678", a_rvld, rdat);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_contention;
        logic [W-1:0] exp_d [0:5];
        logic [AW-1:0] ai, bi;
        logic exp_ag, exp_bg;
        ai = 4'd0; bi = 4'd3;
        for (int c = 0; c < 8; c++) begin
            a_req = (c < 6); a_we = 1'b0; a_addr = ai;
            b_req = (c < 6); b_we = 1'b0; b_addr = bi;
            exp_ag = (c < 6) && (c % 2 == 0);
            exp_bg = (c < 6) && (c % 2 == 1);
            @(negedge clk);
            total_cnt++;
            if (a_gnt !== exp_ag || b_gnt !== exp_bg)
                $display("FAIL cont_gnt[%0d]: got a=%b b=%b expected a=%b b=%b", c, a_gnt, b_gnt, exp_ag, exp_bg);
            else pass_cnt++;
            if (c >= 2) begin
                total_cnt++;
                if (a_rvld !== ((c - 2) % 2 == 0) || b_rvld !== ((c - 2) % 2 == 1) || rdat !== exp_d[c-2])
                    $display("FAIL cont_ret[%0d]: got a_rvld=%b b_rvld=%b rdat=%h expected %b %b %h",
                             c, a_rvld, b_rvld, rdat, ((c - 2) % 2 == 0), ((c - 2) % 2 == 1), exp_d[c-2]);
                else pass_cnt++;
            end
            if (exp_ag) begin exp_d[c] = exp_mem[ai]; ai = ai + 1'b1; end
            if (exp_bg) begin exp_d[c] = exp_mem[bi]; bi = bi + 1'b1; end
            tick;
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_reset_mid_read;
        int n;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        @(negedge clk);
        total_cnt++;
        if (a_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b expected 1", a_gnt); else pass_cnt++;
        tick;
        rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || ram_we !== 1'b0 || a_rvld !== 1'b0)
            $display("FAIL midrst_during: got busy=%b we=%b a_rvld=%b expected 1 0 0", busy, ram_we, a_rvld);
        else pass_cnt++;
        tick;
        rst = 1'b0; rr = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_rvld !== 1'b0 || busy !== 1'b1 || ram_a !== '0)
            $display("FAIL midrst_drop: got a_rvld=%b busy=%b ram_a=%0d expected 0 1 0", a_rvld, busy, ram_a);
        else pass_cnt++;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick;
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (busy !== 1'b0 || n != DEPTH)
            $display("FAIL midrst_reinit: got busy=%b after %0d cycles expected 0 after %0d", busy, n, DEPTH);
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = IV;
        tick;
    endtask

    task automatic test_mixed;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdat = 32'hDEAD0000;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
        @(negedge clk);
        total_cnt++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_we !== 1'b1)
            $display("FAIL mixed_first: got a=%b b=%b we=%b expected 1 0 1", a_gnt, b_gnt, ram_we);
        else pass_cnt++;
        exp_mem[7] = 32'hDEAD0000;
        rr = 1'b1;
        tick;
        a_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1)
            $display("FAIL mixed_second: got a=%b b=%b expected 0 1", a_gnt, b_gnt);
        else pass_cnt++;
        tick;
        b_req = 1'b0;
        tick;
        @(negedge clk);
        total_cnt++;
        if (b_rvld !== 1'b1 || a_rvld !== 1'b0 || rdat !== 32'hDEAD0000)
            $display("FAIL mixed_ret: got b_rvld=%b a_rvld=%b rdat=%h expected 1 0 dead0000", b_rvld, a_rvld, rdat);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_random;
        ret_t q[$];
        ret_t r;
        logic ga, gb, have_last;
        logic [AW-1:0] last_a;
        have_last = 1'b0;
        last_a = '0;
        for (int c = 0; c < 404; c++) begin
            if (c < 400) begin
                if (!a_req && $urandom_range(0, 2) != 0) begin
                    a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                    a_addr = AW'($urandom_range(0, 7)); a_wdat = $urandom;
                end
                if (!b_req && $urandom_range(0, 2) != 0) begin
                    b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
                    b_addr = AW'($urandom_range(0, 7)); b_wdat = $urandom;
                end
            end
            ga = a_req && (!b_req || !rr);
            gb = b_req && !ga;
            @(negedge clk);
            total_cnt++;
            if (a_gnt !== ga || b_gnt !== gb)
                $display("FAIL rnd_gnt[%0d]: got a=%b b=%b expected a=%b b=%b", c, a_gnt, b_gnt, ga, gb);
            else pass_cnt++;
            total_cnt++;
            if (ga && (ram_a !== a_addr || ram_we !== a_we || (a_we && ram_di !== a_wdat)))
                $display("FAIL rnd_mux_a[%0d]: got a=%0d we=%b di=%h expected a=%0d we=%b di=%h", c, ram_a, ram_we, ram_di, a_addr, a_we, a_wdat);
            else if (gb && (ram_a !== b_addr || ram_we !== b_we || (b_we && ram_di !== b_wdat)))
                $display("FAIL rnd_mux_b[%0d]: got a=%0d we=%b di=%h expected a=%0d we=%b di=%h", c, ram_a, ram_we, ram_di, b_addr, b_we, b_wdat);
            else if (!ga && !gb && (ram_we !== 1'b0 || (have_last && ram_a !== last_a)))
                $display("FAIL rnd_idle[%0d]: got we=%b a=%0d expected we=0 a=%0d", c, ram_we, ram_a, last_a);
            else pass_cnt++;
            total_cnt++;
            if (q.size() > 0 && q[0].due == c) begin
                r = q.pop_front();
                if (a_rvld !== (r.own == 1'b0) || b_rvld !== (r.own == 1'b1) || rdat !== r.d)
                    $display("FAIL rnd_ret[%0d]: got a_rvld=%b b_rvld=%b rdat=%h expected owner=%b rdat=%h", c, a_rvld, b_rvld, rdat, r.own, r.d);
                else pass_cnt++;
            end else begin
                if ({a_rvld, b_rvld} !== 2'b00)
                    $display("FAIL rnd_spurious[%0d]: got a_rvld=%b b_rvld=%b expected 0 0", c, a_rvld, b_rvld);
                else pass_cnt++;
            end
            if (a_req && b_req) rr = ga;
            if (ga) begin
                if (a_we) exp_mem[a_addr] = a_wdat;
                else q.push_back('{due: c + 2, own: 1'b0, d: exp_mem[a_addr]});
                last_a = a_addr; have_last = 1'b1;
            end
            if (gb) begin
                if (b_we) exp_mem[b_addr] = b_wdat;
                else q.push_back('{due: c + 2, own: 1'b1, d: exp_mem[b_addr]});
                last_a = b_addr; have_last = 1'b1;
            end
            tick;
            if (ga) a_req = 1'b0;
            if (gb) b_req = 1'b0;
        end
        total_cnt++;
        if (q.size() != 0) $display("FAIL rnd_drain: got %0d reads outstanding expected 0", q.size());
        else pass_cnt++;
    endtask

    initial begin
        rr = 1'b0;
        test_reset;
        test_init_sweep;
        test_init_request;
        test_single;
        test_contention;
        test_reset_mid_read;
        test_mixed;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
